// File: rtl/rv32i_decode_stage_pkg.sv
// Shared types and encodings for the RV32I ID stage: opcodes, ALU ops, immediate
// formats, funct3 values and the ID/EX register layout.
package rv32i_decode_stage_pkg;

  localparam int unsigned Xlen     = 32;
  localparam int unsigned RegAddrW = 5;

  localparam logic [6:0] OpNop    = 7'h00;
  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpImm    = 7'h13;
  localparam logic [6:0] OpAuipc  = 7'h17;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpReg    = 7'h33;
  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpJalr   = 7'h67;
  localparam logic [6:0] OpJal    = 7'h6f;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3SrlSra = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra,
    AluOr, AluAnd, AluBeq, AluBne, AluBlt, AluBge, AluBltu, AluBgeu
  } alu_op_e;

  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ, ImmNone} imm_fmt_e;

  typedef struct packed {
    alu_op_e         alu_op;
    logic [Xlen-1:0] imm;
    logic            src_a_pc;
    logic            src_a_zero;
    logic            src_b_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            rs1_used;
    logic            rs2_used;
    logic            illegal;
    logic            is_nop;
  } dec_t;

  typedef struct packed {
    logic                valid;
    logic [Xlen-1:0]     pc;
    logic [6:0]          op;
    alu_op_e             alu_op;
    logic [2:0]          funct3;
    logic [Xlen-1:0]     imm;
    logic [Xlen-1:0]     rs1_data;
    logic [Xlen-1:0]     rs2_data;
    logic [RegAddrW-1:0] rs1;
    logic [RegAddrW-1:0] rs2;
    logic [RegAddrW-1:0] rd;
    logic                src_a_pc;
    logic                src_a_zero;
    logic                src_b_imm;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                illegal;
  } id_ex_t;

  // alt selects SUB/SRA; callers decide when funct7[5] is meaningful.
  function automatic alu_op_e alu_from_funct3(logic [2:0] f3, logic alt);
    case (f3)
      F3AddSub: return alt ? AluSub : AluAdd;
      F3Sll:    return AluSll;
      F3Slt:    return AluSlt;
      F3Sltu:   return AluSltu;
      F3Xor:    return AluXor;
      F3SrlSra: return alt ? AluSra : AluSrl;
      F3Or:     return AluOr;
      default:  return AluAnd;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_decode_stage_decoder.sv
// Combinational RV32I instruction decoder: ALU op, immediate, control and
// illegal-encoding detection from a raw instruction word.
module rv32i_decoder
  import rv32i_decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  imm_fmt_e   fmt;
  logic       shamt_imm;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    dec       = '0;
    fmt       = ImmNone;
    shamt_imm = 1'b0;

    case (opcode)
      OpLui: begin
        fmt            = ImmU;
        dec.src_a_zero = 1'b1;
        dec.src_b_imm  = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OpAuipc, OpJal: begin
        fmt           = (opcode == OpJal) ? ImmJ : ImmU;
        dec.src_a_pc  = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.reg_write = 1'b1;
      end
      OpJalr: begin
        fmt           = ImmI;
        dec.rs1_used  = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.reg_write = 1'b1;
        dec.illegal   = (f3 != 3'b000);
      end
      OpBranch: begin
        fmt          = ImmB;
        dec.rs1_used = 1'b1;
        dec.rs2_used = 1'b1;
        case (f3)
          F3Beq:   dec.alu_op = AluBeq;
          F3Bne:   dec.alu_op = AluBne;
          F3Blt:   dec.alu_op = AluBlt;
          F3Bge:   dec.alu_op = AluBge;
          F3Bltu:  dec.alu_op = AluBltu;
          F3Bgeu:  dec.alu_op = AluBgeu;
          default: dec.illegal = 1'b1;
        endcase
      end
      OpLoad: begin
        fmt           = ImmI;
        dec.rs1_used  = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.illegal   = !(f3 inside {F3Byte, F3Half, F3Word, F3ByteU, F3HalfU});
      end
      OpStore: begin
        fmt           = ImmS;
        dec.rs1_used  = 1'b1;
        dec.rs2_used  = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.mem_write = 1'b1;
        dec.illegal   = !(f3 inside {F3Byte, F3Half, F3Word});
      end
      OpImm: begin
        fmt           = ImmI;
        dec.rs1_used  = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_from_funct3(f3, (f3 == F3SrlSra) && f7[5]);
        if (f3 == F3Sll) begin
          shamt_imm   = 1'b1;
          dec.illegal = (f7 != F7Base);
        end else if (f3 == F3SrlSra) begin
          shamt_imm   = 1'b1;
          dec.illegal = (f7 != F7Base) && (f7 != F7Alt);
        end
      end
      OpReg: begin
        dec.rs1_used  = 1'b1;
        dec.rs2_used  = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_from_funct3(f3, f7[5]);
        // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
        dec.illegal   = !((f7 == F7Base) ||
                          ((f7 == F7Alt) && ((f3 == F3AddSub) || (f3 == F3SrlSra))));
      end
      OpNop:   dec.is_nop = 1'b1;
      default: dec.illegal = 1'b1;
    endcase

    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
    end
    if (rd == 5'd0) dec.reg_write = 1'b0;

    case (fmt)
      ImmI:    dec.imm = {{20{instr[31]}}, instr[31:20]};
      ImmS:    dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmU:    dec.imm = {instr[31:12], 12'b0};
      ImmJ:    dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                          1'b0};
      default: dec.imm = '0;
    endcase
    if (shamt_imm) dec.imm = {27'b0, instr[24:20]};
  end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I ID stage: decode, register-file read, load-use hazard detection and the
// ID/EX pipeline register.
module rv32i_decode_stage
  import rv32i_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN       = Xlen,
  parameter int unsigned REG_ADDR_W = RegAddrW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  input  logic [XLEN-1:0]       if_pc,
  output logic                  id_ready,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic [REG_ADDR_W-1:0] rf_rs1_addr,
  output logic [REG_ADDR_W-1:0] rf_rs2_addr,
  input  logic [XLEN-1:0]       rf_rs1_data,
  input  logic [XLEN-1:0]       rf_rs2_data,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [6:0]            ex_op,
  output logic [3:0]            ex_alu_op,
  output logic [2:0]            ex_funct3,
  output logic [XLEN-1:0]       ex_imm,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_src_a_pc,
  output logic                  ex_src_a_zero,
  output logic                  ex_src_b_imm,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_illegal
);

  dec_t                dec;
  id_ex_t              id_ex_d, id_ex_q;
  logic [RegAddrW-1:0] rs1, rs2, rd;
  logic                load_use;

  rv32i_decoder u_decoder (
    .instr (if_instr),
    .dec   (dec)
  );

  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];
  assign rd  = if_instr[11:7];

  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;

  assign load_use = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != '0) &&
                    ((dec.rs1_used && (rs1 == id_ex_q.rd)) ||
                     (dec.rs2_used && (rs2 == id_ex_q.rd)));

  // Forced high in reset so IF never sees a stale hazard while the pipe clears.
  assign id_ready = !rst_n || (!ex_stall && !load_use);

  // Bubbles are captured as an all-zero entry so no stray control reaches EX.
  always_comb begin
    id_ex_d = '0;
    if (if_valid && !dec.is_nop && !load_use) begin
      id_ex_d.valid      = 1'b1;
      id_ex_d.pc         = if_pc;
      id_ex_d.op         = if_instr[6:0];
      id_ex_d.alu_op     = dec.alu_op;
      id_ex_d.funct3     = if_instr[14:12];
      id_ex_d.imm        = dec.imm;
      id_ex_d.rs1_data   = rf_rs1_data;
      id_ex_d.rs2_data   = rf_rs2_data;
      id_ex_d.rs1        = dec.rs1_used ? rs1 : '0;
      id_ex_d.rs2        = dec.rs2_used ? rs2 : '0;
      id_ex_d.rd         = rd;
      id_ex_d.src_a_pc   = dec.src_a_pc;
      id_ex_d.src_a_zero = dec.src_a_zero;
      id_ex_d.src_b_imm  = dec.src_b_imm;
      id_ex_d.reg_write  = dec.reg_write;
      id_ex_d.mem_read   = dec.mem_read;
      id_ex_d.mem_write  = dec.mem_write;
      id_ex_d.illegal    = dec.illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex_q <= '0;
    end else if (flush) begin
      id_ex_q <= '0;
    end else if (!ex_stall) begin
      id_ex_q <= id_ex_d;
    end
  end

  assign ex_valid      = id_ex_q.valid;
  assign ex_pc         = id_ex_q.pc;
  assign ex_op         = id_ex_q.op;
  assign ex_alu_op     = id_ex_q.alu_op;
  assign ex_funct3     = id_ex_q.funct3;
  assign ex_imm        = id_ex_q.imm;
  assign ex_rs1_data   = id_ex_q.rs1_data;
  assign ex_rs2_data   = id_ex_q.rs2_data;
  assign ex_rs1        = id_ex_q.rs1;
  assign ex_rs2        = id_ex_q.rs2;
  assign ex_rd         = id_ex_q.rd;
  assign ex_src_a_pc   = id_ex_q.src_a_pc;
  assign ex_src_a_zero = id_ex_q.src_a_zero;
  assign ex_src_b_imm  = id_ex_q.src_b_imm;
  assign ex_reg_write  = id_ex_q.reg_write;
  assign ex_mem_read   = id_ex_q.mem_read;
  assign ex_mem_write  = id_ex_q.mem_write;
  assign ex_illegal    = id_ex_q.illegal;

endmodule

// File: doc/rv32i_decode_stage.md
Name: rv32i_decode_stage

Overview:
- ID stage of the 5-stage RV32I pipeline. It takes fetched instruction words from IF, classifies them by OP_Code, and maps them to ALU_OP.
- It generates immediates and control signals, reads the register file, detects load-use hazards, and holds the ID/EX pipeline register consumed by EX.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- if_valid  in  1  IF presents a valid instruction
- if_instr  in  32  instruction word
- if_pc  in  XLEN  PC of if_instr
- id_ready  out  1  ID accepts this cycle; low during stall
- ex_stall  in  1  EX/MEM cannot accept; hold ID/EX register
- flush  in  1  branch/jump redirect; kill ID and the ID/EX contents
- rf_rs1_addr  out  REG_ADDR_W  regfile read address 1 (combinational from if_instr)
- rf_rs2_addr  out  REG_ADDR_W  regfile read address 2
- rf_rs1_data  in  XLEN  regfile read data 1 (same cycle)
- rf_rs2_data  in  XLEN  regfile read data 2
- ex_valid  out  1  ID/EX holds a live instruction
- ex_pc  out  XLEN  PC
- ex_op  out  7  OP_Code
- ex_alu_op  out  4  ALU_OP
- ex_funct3  out  3  width/sign for LSU
- ex_imm  out  XLEN  sign-extended immediate
- ex_rs1_data, ex_rs2_data  out  XLEN  operands
- ex_rs1, ex_rs2, ex_rd  out  REG_ADDR_W  register indices, for forwarding
- ex_src_a_pc  out  1  operand A = PC (AUIPC, JAL)
- ex_src_a_zero  out  1  operand A = 0 (LUI)
- ex_src_b_imm  out  1  operand B = immediate
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  control
- ex_illegal  out  1  unrecognised encoding

Behaviour:
- Reset: when rst_n is low on a clk edge, every ex_* output is 0 (ex_op = NOP, ex_alu_op = ADD). id_ready is combinational and is 1 while in reset.
- Latency: 1 cycle. An instruction accepted at edge N appears on ex_* after edge N.
- Per-edge priority, in order:
  - flush: ex_valid <= 0 and all control <= 0.
  - ex_stall: hold every ex_* register.
  - load-use: ex_valid <= 0 (bubble).
  - otherwise: capture the decode of if_instr; ex_valid <= if_valid.
- load_use = ex_valid & ex_mem_read & ex_rd != 0 & ((rs1 used & rs1 == ex_rd) | (rs2 used & rs2 == ex_rd)).
  - rs1 is used for all opcodes except LUI, AUIPC, JAL.
  - rs2 is used for R_TYPE, STORE, BRANCH.
- id_ready = ~ex_stall & ~load_use. flush does not lower id_ready; IF squashes itself on a flush.
- ALU_OP mapping:
  - R_TYPE: by funct3. funct3=000 gives SUB if funct7[5]=1, else ADD. funct3=101 gives SRA if funct7[5]=1, else SRL.
  - IMM: same as R_TYPE, except 000 is always ADD. Shift immediates with funct7 other than 0000000/0100000 are illegal.
  - BRANCH: 000→BEQ, 001→BNE, 100→BLT, 101→BGE, 110→BLTU, 111→BGEU. 010 and 011 are illegal.
  - LOAD, STORE, LUI, AUIPC, JAL, JALR: ADD.
- Immediates: I-, S-, B-, U- and J-type per the RV32I formats, sign-extended to XLEN. B and J immediates have bit 0 = 0. R_TYPE immediate is 0.
- reg_write = 1 for LOAD, R_TYPE, IMM, LUI, AUIPC, JAL, JALR; forced to 0 when rd = 0.
- Opcode NOP (all-zero) is a bubble: ex_valid = 0, not illegal.
- Illegal instruction (any other unknown opcode, or bad funct): ex_valid = 1, ex_illegal = 1, reg_write = mem_read = mem_write = 0.
- if_valid = 0 with no stall: bubble captured.
- flush with ex_stall asserted in the same cycle: flush wins.

Decomposition:
- Add the following to package core:
  - immediate-format enum IMM_FMT {I, S, B, U, J, NONE}
  - packed struct id_ex_t holding every ex_* field
  - funct3 localparams
- One natural sub-module, rv32i_decoder: purely combinational, instr → {alu_op, imm, control, illegal}.
- The hazard logic and the ID/EX register stay in rv32i_decode_stage.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rf data 5/7 → next cycle: ex_alu_op = ADD, ex_rd = 3, ex_reg_write = 1, ex_rs1_data = 5, ex_rs2_data = 7.
- SUB (0x402081B3), then SRAI x5,x5,3 (0x4032D293), then LUI x1,0x12345 (0x123450B7):
  - SUB → SUB.
  - SRAI → SRA, ex_imm = 3.
  - LUI → ex_imm = 0x12345000, ex_src_a_zero = 1.
- LW x4,0(x1), then ADD x5,x4,x4:
  - Cycle after the LW is captured: id_ready = 0 and a bubble is inserted.
  - ADD is captured one cycle later.
  - The same sequence with rd = x0 causes no stall.
- BEQ with imm = −8 (0xFE208CE3) → ex_alu_op = BEQ, ex_imm = 0xFFFFFFF8, ex_reg_write = 0. funct3 = 010 → ex_illegal = 1.
- ex_stall held for 3 cycles: ex_* stays constant and id_ready = 0. flush asserted together with ex_stall → ex_valid = 0 on the next cycle.
- rst_n low mid-stream for 1 cycle → all ex_* = 0; the next valid instruction decodes normally.
